// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle between a synchronous FIFO, the fifo_rd_stream adapter and its stream consumer.
// The master modport is the adapter's view; the slave modport is the FIFO-plus-consumer side.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 2
);
    logic                  fifo_rd;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output fifo_rd,
        output m_valid,
        output m_data,
        input  fifo_empty,
        input  fifo_data,
        input  m_ready
    );

    modport slave (
        input  fifo_rd,
        input  m_valid,
        input  m_data,
        output fifo_empty,
        output fifo_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO into a valid/ready stream through a small skid buffer.
// Define FIFO_RD_STREAM_STATS_EN to add saturating word_cnt / stall_cnt outputs.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 2,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drain_en,
    fifo_rd_stream_if.master bus,
    output logic             busy
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LATENCY + 1);
    localparam int SUM_W = $clog2(BUF_DEPTH + RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [RD_LATENCY-1:0]   rd_pipe_q, rd_pipe_d;
    logic [DATA_WIDTH-1:0]   buf_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0]   buf_d [BUF_DEPTH];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic [INF_W-1:0]        inflight;
    logic                    room;
    logic                    pending;
    logic                    rd;
    logic                    push;
    logic                    pop;
    logic                    m_valid;

    // Reserve a slot for every word already requested so a full buffer never overflows.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + INF_W'(rd_pipe_q[i]);
        end
    end

    assign room    = (SUM_W'(occ_q) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH);
    assign pending = (occ_q != '0) || (inflight != '0);
    assign rd      = (state_q == ACTIVE) && drain_en && !bus.fifo_empty && room;
    assign push    = rd_pipe_q[RD_LATENCY-1];
    assign m_valid = (occ_q != '0);
    assign pop     = m_valid && bus.m_ready;

    assign bus.fifo_rd = rd;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = buf_q[head_q];
    assign busy        = (state_q != IDLE);

    always_comb begin
        rd_pipe_d    = '0;
        rd_pipe_d[0] = rd;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (drain_en) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!drain_en) state_d = pending ? STOPPING : IDLE;
            end
            STOPPING: begin
                if (drain_en)      state_d = ACTIVE;
                else if (!pending) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (pop)  head_d = head_q + PTR_W'(1);
        if (push) tail_d = tail_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Returning words land at the tail when their request bit leaves the pipeline.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_buf
            always_comb begin
                buf_d[gi] = buf_q[gi];
                if (push && (tail_q == PTR_W'(gi))) buf_d[gi] = bus.fifo_data;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) buf_q[gi] <= '0;
                else     buf_q[gi] <= buf_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_pipe_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_pipe_q <= rd_pipe_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        word_cnt_d  = word_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop && (word_cnt_q != '1))                    word_cnt_d  = word_cnt_q + CNT_WIDTH'(1);
        if (m_valid && !bus.m_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (read latency 1 and 2) share drain_en/m_ready and each
// is fed by its own emulated FIFO; a transaction-level model predicts every output each cycle.
module tb_fifo_rd_stream;

    localparam int DW    = 2;
    localparam int DEPTH = 4;
    localparam int NI    = 2;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst;
    logic drain_en;
    logic m_ready;

    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus0 ();
    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus1 ();

    logic [NI-1:0] busy_o;
    logic [NI-1:0] o_rd;
    logic [NI-1:0] o_val;
    logic [DW-1:0] o_data [NI];
    logic [NI-1:0] f_empty;
    logic [DW-1:0] f_data [NI];
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [CW-1:0] wc_o [NI];
    logic [CW-1:0] sc_o [NI];
`endif

    assign bus0.fifo_empty = f_empty[0];
    assign bus1.fifo_empty = f_empty[1];
    assign bus0.fifo_data  = f_data[0];
    assign bus1.fifo_data  = f_data[1];
    assign bus0.m_ready    = m_ready;
    assign bus1.m_ready    = m_ready;
    assign o_rd            = {bus1.fifo_rd, bus0.fifo_rd};
    assign o_val           = {bus1.m_valid, bus0.m_valid};
    assign o_data[0]       = bus0.m_data;
    assign o_data[1]       = bus1.m_data;

    fifo_rd_stream #(
        .DATA_WIDTH(DW), .RD_LATENCY(1), .BUF_DEPTH(DEPTH)
`ifdef FIFO_RD_STREAM_STATS_EN
        , .CNT_WIDTH(CW)
`endif
    ) u_dut0 (
        .clk(clk), .rst(rst), .drain_en(drain_en), .bus(bus0), .busy(busy_o[0])
`ifdef FIFO_RD_STREAM_STATS_EN
        , .word_cnt(wc_o[0]), .stall_cnt(sc_o[0])
`endif
    );

    fifo_rd_stream #(
        .DATA_WIDTH(DW), .RD_LATENCY(2), .BUF_DEPTH(DEPTH)
`ifdef FIFO_RD_STREAM_STATS_EN
        , .CNT_WIDTH(CW)
`endif
    ) u_dut1 (
        .clk(clk), .rst(rst), .drain_en(drain_en), .bus(bus1), .busy(busy_o[1])
`ifdef FIFO_RD_STREAM_STATS_EN
        , .word_cnt(wc_o[1]), .stall_cnt(sc_o[1])
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Emulated FIFO contents and the words each instance owes the consumer, in order.
    logic [DW-1:0] fmem     [NI][64];
    int            fhead    [NI];
    int            ftail    [NI];
    logic [DW-1:0] oq_data  [NI][16];
    int            oq_avail [NI][16];
    int            oq_head  [NI];
    int            oq_tail  [NI];
    logic [DW-1:0] fd_pipe  [NI][2];
    bit            m_busy   [NI];
    bit            m_active [NI];
    int            m_wc     [NI];
    int            m_sc     [NI];
    bit            last_rd  [NI];
    int            rd_cnt   [NI];
    int            pop_cnt  [NI];
    int            snap_rd  [NI];
    int            snap_pop [NI];

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, inst, cyc, obs, exp);
        end
    endtask

    task automatic load(input int n, input bit seq);
        logic [DW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = seq ? DW'(k % 4) : DW'($urandom);
            for (int i = 0; i < NI; i++) begin
                fmem[i][ftail[i] % 64] = w;
                ftail[i]++;
            end
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < NI; i++) begin
            snap_rd[i]  = rd_cnt[i];
            snap_pop[i] = pop_cnt[i];
        end
    endtask

    // One clock cycle: compare at negedge+1, then advance the model past the rising edge.
    task automatic step();
        int outst;
        bit e_rd  [NI];
        bit e_val [NI];
        bit pend  [NI];
        for (int i = 0; i < NI; i++) f_empty[i] = (fhead[i] == ftail[i]);
        #1;
        for (int i = 0; i < NI; i++) begin
            outst    = oq_tail[i] - oq_head[i];
            e_rd[i]  = m_active[i] && drain_en && (fhead[i] != ftail[i]) && (outst < DEPTH);
            e_val[i] = (outst > 0) && (oq_avail[i][oq_head[i] % 16] <= cyc);
            pend[i]  = (outst != 0);
            chk("fifo_rd", i, 32'(o_rd[i]), 32'(e_rd[i]));
            chk("m_valid", i, 32'(o_val[i]), 32'(e_val[i]));
            if (e_val[i]) chk("m_data", i, 32'(o_data[i]), 32'(oq_data[i][oq_head[i] % 16]));
            chk("busy", i, 32'(busy_o[i]), 32'(m_busy[i]));
`ifdef FIFO_RD_STREAM_STATS_EN
            chk("word_cnt", i, 32'(wc_o[i]), 32'(m_wc[i]));
            chk("stall_cnt", i, 32'(sc_o[i]), 32'(m_sc[i]));
`endif
            last_rd[i] = o_rd[i];
            if (o_rd[i]) rd_cnt[i]++;
            if (o_val[i] && m_ready) pop_cnt[i]++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            m_busy[i]   = drain_en || (m_busy[i] && pend[i]);
            m_active[i] = drain_en;
            if (e_val[i] && m_ready && m_wc[i] < (2**CW - 1)) m_wc[i]++;
            if (e_val[i] && !m_ready && m_sc[i] < (2**CW - 1)) m_sc[i]++;
            if (e_val[i] && m_ready) oq_head[i]++;
            fd_pipe[i][1] = fd_pipe[i][0];
            if (e_rd[i]) begin
                oq_data[i][oq_tail[i] % 16]  = fmem[i][fhead[i] % 64];
                oq_avail[i][oq_tail[i] % 16] = cyc + lat(i);
                oq_tail[i]++;
                fd_pipe[i][0] = fmem[i][fhead[i] % 64];
                fhead[i]++;
            end else begin
                fd_pipe[i][0] = DW'($urandom);
            end
            f_data[i]  = fd_pipe[i][lat(i) - 1];
            f_empty[i] = (fhead[i] == ftail[i]);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Reset is raised mid-cycle; outputs must clear before any clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_fifo_rd", i, 32'(o_rd[i]), 32'd0);
            chk("rst_m_valid", i, 32'(o_val[i]), 32'd0);
            chk("rst_m_data", i, 32'(o_data[i]), 32'd0);
            chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
            oq_head[i]  = 0;
            oq_tail[i]  = 0;
            fhead[i]    = 0;
            ftail[i]    = 0;
            m_busy[i]   = 1'b0;
            m_active[i] = 1'b0;
            m_wc[i]     = 0;
            m_sc[i]     = 0;
            f_empty[i]  = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        drain_en = 1'b0;
        m_ready  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            f_empty[i]    = 1'b1;
            f_data[i]     = '0;
            fd_pipe[i][0] = '0;
            fd_pipe[i][1] = '0;
            rd_cnt[i]     = 0;
            pop_cnt[i]    = 0;
            last_rd[i]    = 1'b0;
        end
        @(negedge clk);
        async_reset();
        run(2);

        // Streaming at full rate.
        load(8, 1'b1);
        snapshot();
        drain_en = 1'b1;
        m_ready  = 1'b1;
        run(14);
        for (int i = 0; i < NI; i++) begin
            chk("stream_rd_pulses", i, 32'(rd_cnt[i] - snap_rd[i]), 32'd8);
            chk("stream_beats", i, 32'(pop_cnt[i] - snap_pop[i]), 32'd8);
        end
        drain_en = 1'b0;
        run(4);

        // Back-pressure: buffer fills, reads stop, nothing lost.
        load(8, 1'b1);
        snapshot();
        drain_en = 1'b1;
        m_ready  = 1'b0;
        run(10);
        for (int i = 0; i < NI; i++) chk("bp_rd_pulses", i, 32'(rd_cnt[i] - snap_rd[i]), 32'd4);
        m_ready = 1'b1;
        run(16);
        for (int i = 0; i < NI; i++) chk("bp_beats", i, 32'(pop_cnt[i] - snap_pop[i]), 32'd8);
        drain_en = 1'b0;
        run(3);

        // Single word, FIFO then empty.
        load(1, 1'b1);
        snapshot();
        drain_en = 1'b1;
        run(8);
        for (int i = 0; i < NI; i++) begin
            chk("empty_rd_pulses", i, 32'(rd_cnt[i] - snap_rd[i]), 32'd1);
            chk("empty_beats", i, 32'(pop_cnt[i] - snap_pop[i]), 32'd1);
        end
        drain_en = 1'b0;
        run(3);

        // Stop right after a read is issued: in-flight word still delivered.
        load(4, 1'b0);
        snapshot();
        last_rd[1] = 1'b0;
        drain_en   = 1'b1;
        for (int k = 0; k < 10 && !last_rd[1]; k++) step();
        chk("stop_rd_issued", 1, 32'(last_rd[1]), 32'd1);
        drain_en = 1'b0;
        run(8);
        chk("stop_beats", 1, 32'(pop_cnt[1] - snap_pop[1]), 32'd1);
        chk("stop_idle", 1, 32'(busy_o[1]), 32'd0);

        // Reset mid-burst with words buffered and in flight.
        load(8, 1'b1);
        drain_en = 1'b1;
        m_ready  = 1'b0;
        run(5);
        async_reset();
        load(8, 1'b1);
        m_ready = 1'b1;
        snapshot();
        run(14);
        for (int i = 0; i < NI; i++) chk("post_rst_beats", i, 32'(pop_cnt[i] - snap_pop[i]), 32'd8);

        // Random drain/back-pressure traffic with a trickle-filled FIFO.
        for (int k = 0; k < 300; k++) begin
            drain_en = ($urandom_range(0, 7) != 0);
            m_ready  = ($urandom_range(0, 2) != 0);
            if ((ftail[0] - fhead[0]) < 40 && $urandom_range(0, 3) == 0) load(4, 1'b0);
            step();
        end
        drain_en = 1'b0;
        m_ready  = 1'b1;
        run(8);
        for (int i = 0; i < NI; i++) chk("final_idle", i, 32'(busy_o[i]), 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
        for (int i = 0; i < NI; i++) chk("word_cnt_sat", i, 32'(wc_o[i]), 32'd15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
